axi_spy_drain: RTL
==================

AXI_SPY_DRAIN -- requirements
Module: axi_spy_drain

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of AR/AW spy FIFO entries.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of R/W spy FIFO entries.
REQ-003 SHALL have parameter REC_WIDTH, default 32: output payload width; SHALL be >= ADDR_WIDTH and >= DATA_WIDTH.
REQ-004 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 r_empty, ar_empty, w_empty, aw_empty  input  1 each  empty flag of the matching spy FIFO.
REQ-008 r_pop_data, w_pop_data  input  DATA_WIDTH; ar_pop_data, aw_pop_data  input  ADDR_WIDTH  head entry; valid whenever the matching empty flag is 0 (first-word-fall-through).
REQ-009 r_pop, ar_pop, w_pop, aw_pop  output  1 each  registered pop strobe; FIFO head advances at the rising edge where the strobe is 1.
REQ-010 drain_en  input  1  1 = new records may be started.
REQ-011 out_valid  output  1  record valid.
REQ-012 out_ready  input  1  downstream accepts record.
REQ-013 out_data  output  REC_WIDTH  captured entry, zero-extended.
REQ-014 out_chan  output  2  source: 0=R, 1=AR, 2=W, 3=AW.
REQ-015 out_seq  output  16  record sequence number.

Function
REQ-016 SHALL implement FSM with states IDLE and SEND.
REQ-017 In IDLE, with drain_en=1 and at least one empty flag 0, SHALL grant the first non-empty channel in round-robin order starting at (last_grant+1) mod 4.
REQ-018 On grant, at the same edge, SHALL load out_data/out_chan, set out_valid=1, set the granted pop strobe to 1, update last_grant, and move to SEND.
REQ-019 Each pop strobe SHALL be 1 for exactly one cycle per grant (first SEND cycle); at most one pop strobe SHALL be 1 in any cycle.
REQ-020 In SEND, out_valid=1; on out_valid&out_ready SHALL clear out_valid, increment out_seq, and return to IDLE at that edge.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_chan and out_seq SHALL hold stable.
REQ-022 IDLE SHALL last at least one cycle between records; peak throughput is one record per 2 cycles.
REQ-023 Latency: empty falls in cycle N (FSM in IDLE, drain_en=1) -> out_valid=1 in cycle N+1.
REQ-024 drain_en=0 SHALL block new grants only; a record already in SEND SHALL complete normally.
REQ-025 out_seq SHALL start at 0, reflect the count of prior accepted records, and wrap 0xFFFF -> 0x0000.
REQ-026 An empty flag rising while that channel is not granted SHALL have no effect; no pop SHALL ever be issued to a channel whose empty flag was 1 at grant.
REQ-027 All four channels non-empty continuously SHALL yield grant order R, AR, W, AW, R, ...

Reset
REQ-028 While reset=1: FSM=IDLE, out_valid=0, out_data=0, out_chan=0, out_seq=0, all pop strobes=0, last_grant=3 (first grant priority R).
REQ-029 Reset asserted in SEND SHALL discard the pending record; a pop strobe due that cycle SHALL be forced to 0.
REQ-030 Outputs SHALL hold reset values in the first cycle after reset deasserts.

Verification
REQ-031 Single entry: r_empty=0, r_pop_data=0xDEADBEEF, out_ready=1 -> out_valid=1 one cycle later with out_data=0xDEADBEEF, out_chan=0, out_seq=0; r_pop one cycle high.
REQ-032 Round robin: all FIFOs hold 3 entries, out_ready=1 -> out_chan sequence 0,1,2,3 repeated 3 times, out_seq 0..11, one record per 2 cycles.
REQ-033 Backpressure: out_ready=0 for 10 cycles with W record pending -> out_valid, out_data, out_chan=2 stable for 10 cycles, exactly one w_pop, out_seq increments once on acceptance.
REQ-034 drain_en: drop drain_en during SEND -> current record completes; no further pops while drain_en=0 despite non-empty FIFOs.
REQ-035 Wrap: 65537 accepted records -> last out_seq=0x0000.
REQ-036 Reset mid-SEND: reset in the pop cycle -> no pop strobe, out_valid=0 next cycle, out_seq=0, next grant is R.

Source files
------------

// File: rtl/axi_spy_drain.sv
// Drains four AXI spy FIFOs (R, AR, W, AW) into a single record stream.
// Channels are picked round-robin; each grant pops exactly one FIFO entry.
module axi_spy_drain #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r_empty,
  input  logic                  ar_empty,
  input  logic                  w_empty,
  input  logic                  aw_empty,
  input  logic [DATA_WIDTH-1:0] r_pop_data,
  input  logic [ADDR_WIDTH-1:0] ar_pop_data,
  input  logic [DATA_WIDTH-1:0] w_pop_data,
  input  logic [ADDR_WIDTH-1:0] aw_pop_data,
  output logic                  r_pop,
  output logic                  ar_pop,
  output logic                  w_pop,
  output logic                  aw_pop,
  input  logic                  drain_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REC_WIDTH-1:0]  out_data,
  output logic [1:0]            out_chan,
  output logic [15:0]           out_seq
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [1:0]           last_grant_q, last_grant_d;
  logic [3:0]           pop_q, pop_d;
  logic                 valid_q, valid_d;
  logic [REC_WIDTH-1:0] data_q, data_d;
  logic [1:0]           chan_q, chan_d;
  logic [15:0]          seq_q, seq_d;

  logic [3:0]           nonempty;
  logic                 gnt_any;
  logic [1:0]           gnt_idx;
  logic [REC_WIDTH-1:0] gnt_data;

  assign nonempty = ~{aw_empty, w_empty, ar_empty, r_empty};

  // Search starts one past the last grant so every channel gets a turn.
  always_comb begin
    logic [1:0] cand;
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    cand    = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant_q + 2'(i);
      if (!gnt_any && nonempty[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    case (gnt_idx)
      2'd0:    gnt_data = REC_WIDTH'(r_pop_data);
      2'd1:    gnt_data = REC_WIDTH'(ar_pop_data);
      2'd2:    gnt_data = REC_WIDTH'(w_pop_data);
      default: gnt_data = REC_WIDTH'(aw_pop_data);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pop_d        = 4'b0000;
    valid_d      = valid_q;
    data_d       = data_q;
    chan_d       = chan_q;
    seq_d        = seq_q;
    case (state_q)
      IDLE: begin
        if (drain_en && gnt_any) begin
          state_d      = SEND;
          last_grant_d = gnt_idx;
          pop_d        = 4'b0001 << gnt_idx;
          valid_d      = 1'b1;
          data_d       = gnt_data;
          chan_d       = gnt_idx;
        end
      end
      SEND: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          seq_d   = seq_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd3;
      pop_q        <= 4'b0000;
      valid_q      <= 1'b0;
      data_q       <= '0;
      chan_q       <= 2'd0;
      seq_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pop_q        <= pop_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      chan_q       <= chan_d;
      seq_q        <= seq_d;
    end
  end

  // A reset arriving in the pop cycle must not advance the FIFO head.
  assign r_pop  = pop_q[0] & ~reset;
  assign ar_pop = pop_q[1] & ~reset;
  assign w_pop  = pop_q[2] & ~reset;
  assign aw_pop = pop_q[3] & ~reset;

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_seq   = seq_q;

endmodule
